execute_pipe: RTL

Parametrised execute stage for the soft ARM-style core; sits between Decode and the external data cache. Holds the register file and NZCV flags, runs single-cycle ALU micro-ops, sequences multi-cycle loads and stores through a req/ack data-memory port, and evaluates ARM condition codes. A taken branch produces a PC delta and squashes a configurable number of following instructions. Unlike the previous execute stage, it back-pressures Decode during memory access and has a defined reset state.

---
 rtl/execute_pipe.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/execute_pipe.sv
// Execute stage: register file, NZCV flags, single-cycle ALU, req/ack load/store sequencing,
// ARM condition evaluation and branch squash window.
module execute_pipe #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned NREGS        = 16,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 uop,
  input  logic [$clog2(NREGS)-1:0]   sel_p0,
  input  logic [$clog2(NREGS)-1:0]   sel_p1,
  input  logic [$clog2(NREGS)-1:0]   sel_in,
  input  logic                       num_to_rhs,
  input  logic [DATA_W-1:0]          num,
  input  logic [3:0]                 branch_cond,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [DATA_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic                       mem_ack,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic                       global_disable,
  output logic                       delta_valid,
  output logic [DATA_W-1:0]          delta_instruction
);

  localparam int unsigned RW = $clog2(NREGS);
  localparam int unsigned CW = $clog2(FLUSH_CYCLES + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MEM  = 1'b1;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_MOV = 4'd5;
  localparam logic [3:0] OP_CMP = 4'd6;
  localparam logic [3:0] OP_LDR = 4'd7;
  localparam logic [3:0] OP_STR = 4'd8;
  localparam logic [3:0] OP_B   = 4'd9;

  logic [DATA_W-1:0] regs [NREGS];
  logic              flag_n, flag_z, flag_c, flag_v;
  logic [0:0]        state;
  logic [CW-1:0]     squash_cnt;
  logic              mem_ldr;
  logic [RW-1:0]     mem_dest;

  logic              fire, squashing, exec;
  logic [DATA_W-1:0] lhs, rhs, store_data;
  logic [DATA_W:0]   sum_ext, diff_ext;
  logic [DATA_W-1:0] alu_res;
  logic              alu_op, alu_wr, upd_cv;
  logic              n_d, z_d, c_d, v_d;
  logic              cond_pass;

  assign in_ready       = (state == IDLE);
  assign squashing      = (squash_cnt != '0);
  assign global_disable = squashing;
  assign fire           = in_valid & in_ready;
  assign exec           = fire & ~squashing;

  assign lhs        = regs[sel_p1];
  assign store_data = regs[sel_p0];
  assign rhs        = num_to_rhs ? num : regs[sel_p0];

  // Carry out of lhs + ~rhs + 1 is the ARM "no borrow" carry.
  assign sum_ext  = {1'b0, lhs} + {1'b0, rhs};
  assign diff_ext = {1'b0, lhs} + {1'b0, ~rhs} + {{DATA_W{1'b0}}, 1'b1};

  always_comb begin
    alu_res = '0;
    alu_op  = 1'b1;
    alu_wr  = 1'b1;
    upd_cv  = 1'b0;
    c_d     = flag_c;
    v_d     = flag_v;
    case (uop)
      OP_ADD: begin
        alu_res = sum_ext[DATA_W-1:0];
        upd_cv  = 1'b1;
        c_d     = sum_ext[DATA_W];
        v_d     = (lhs[DATA_W-1] == rhs[DATA_W-1]) && (alu_res[DATA_W-1] != lhs[DATA_W-1]);
      end
      OP_SUB, OP_CMP: begin
        alu_res = diff_ext[DATA_W-1:0];
        alu_wr  = (uop == OP_SUB);
        upd_cv  = 1'b1;
        c_d     = diff_ext[DATA_W];
        v_d     = (lhs[DATA_W-1] != rhs[DATA_W-1]) && (alu_res[DATA_W-1] != lhs[DATA_W-1]);
      end
      OP_AND:  alu_res = lhs & rhs;
      OP_OR:   alu_res = lhs | rhs;
      OP_XOR:  alu_res = lhs ^ rhs;
      OP_MOV:  alu_res = rhs;
      default: begin
        alu_op = 1'b0;
        alu_wr = 1'b0;
      end
    endcase
    n_d = alu_res[DATA_W-1];
    z_d = (alu_res == '0);
  end

  always_comb begin
    cond_pass = 1'b0;
    case (branch_cond)
      4'd0:    cond_pass = flag_z;
      4'd1:    cond_pass = ~flag_z;
      4'd2:    cond_pass = flag_c;
      4'd3:    cond_pass = ~flag_c;
      4'd4:    cond_pass = flag_n;
      4'd5:    cond_pass = ~flag_n;
      4'd6:    cond_pass = flag_v;
      4'd7:    cond_pass = ~flag_v;
      4'd8:    cond_pass = flag_c & ~flag_z;
      4'd9:    cond_pass = ~flag_c | flag_z;
      4'd10:   cond_pass = (flag_n == flag_v);
      4'd11:   cond_pass = (flag_n != flag_v);
      4'd12:   cond_pass = ~flag_z & (flag_n == flag_v);
      4'd13:   cond_pass = flag_z | (flag_n != flag_v);
      4'd14:   cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
      flag_n            <= 1'b0;
      flag_z            <= 1'b0;
      flag_c            <= 1'b0;
      flag_v            <= 1'b0;
      state             <= IDLE;
      squash_cnt        <= '0;
      mem_ldr           <= 1'b0;
      mem_dest          <= '0;
      mem_req           <= 1'b0;
      mem_we            <= 1'b0;
      mem_addr          <= '0;
      mem_wdata         <= '0;
      delta_valid       <= 1'b0;
      delta_instruction <= '0;
    end else begin
      delta_valid       <= 1'b0;
      delta_instruction <= '0;

      if (fire && squashing) squash_cnt <= squash_cnt - 1'b1;

      if (exec && alu_op) begin
        if (alu_wr) regs[sel_in] <= alu_res;
        flag_n <= n_d;
        flag_z <= z_d;
        if (upd_cv) begin
          flag_c <= c_d;
          flag_v <= v_d;
        end
      end

      if (exec && (uop == OP_LDR || uop == OP_STR)) begin
        state     <= MEM;
        mem_req   <= 1'b1;
        mem_we    <= (uop == OP_STR);
        mem_addr  <= lhs + num;
        mem_wdata <= (uop == OP_STR) ? store_data : '0;
        mem_ldr   <= (uop == OP_LDR);
        mem_dest  <= sel_in;
      end

      if (exec && uop == OP_B && cond_pass) begin
        delta_valid       <= 1'b1;
        delta_instruction <= num;
        squash_cnt        <= CW'(FLUSH_CYCLES);
      end

      // No acceptance can occur in MEM, so this write never collides with an ALU write.
      if (state == MEM && mem_ack) begin
        state   <= IDLE;
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
        if (mem_ldr) regs[mem_dest] <= mem_rdata;
      end
    end
  end

endmodule
